spi_slave: RTL and testbench
============================

# spi_slave

SPI mode-0 responder that terminates the SPI link driven by the verification master, used as the DUT behind the `miso/mosi/cs/sclk` interface. It oversamples `sclk`, `cs` and `mosi` on the system clock, decodes a 16-bit header (2-bit opcode, 14-bit address) and then either writes a 32-bit word to a register back-end or reads one. Reads insert 2 turnaround `sclk` cycles before the data. All bits travel MSB first.

## Interface
- `HDR_LEN`, 16: header bits, {opcode[1:0], addr[13:0]}
- `ADD_LEN`, 14: address width
- `DLY_LEN`, 2: read turnaround, in `sclk` cycles
- `DATA_LEN`, 32: data word width
- `SYNC_STAGES`, 2: synchronizer depth on `sclk`, `cs`, `mosi`

Ports:
- `clk`  in  1  system clock; the only clock
- `rst`  in  1  synchronous, active-high reset
- `sclk`  in  1  SPI clock from the master, asynchronous to `clk`
- `cs`  in  1  chip select, active low
- `mosi`  in  1  master-out data
- `miso`  out  1  slave-out data
- `miso_oe`  out  1  `miso` output enable; high only while read data is shifted
- `wr_en`  out  1  one-`clk` write strobe
- `wr_addr`  out  ADD_LEN  write address
- `wr_data`  out  DATA_LEN  write data
- `rd_en`  out  1  one-`clk` read strobe
- `rd_addr`  out  ADD_LEN  read address
- `rd_data`  in  DATA_LEN  read data, valid exactly 1 `clk` after `rd_en`
- `frame_done`  out  1  one-`clk` pulse when a legal frame completes
- `frame_err`  out  1  one-`clk` pulse on an illegal opcode or an aborted frame

## Operation
- Input path: `SYNC_STAGES` flops, then one edge-detect register. This produces `sclk_rise`, `sclk_fall`, `cs_fall` and `cs_rise` strobes, each one `clk` wide.
- `mosi` is sampled from the synchronized copy on `sclk_rise`.
- A bit counter (6 bits) counts `sclk_rise` events within a frame.
- States:
  - IDLE: `miso`=0, `miso_oe`=0. Go to HDR on `cs_fall`; clear the counter and the shift register.
  - HDR: shift `mosi` on each rise. After rise 16, decode the opcode:
    - 2'b01 (write): go to WDATA.
    - 2'b10 (read): pulse `rd_en` with `rd_addr`=addr on the next `clk`, capture `rd_data` 1 `clk` later, go to TURN.
    - 2'b00 / 2'b11: pulse `frame_err`, go to IGNORE.
  - WDATA: shift 32 bits on rises 17..48. On the `clk` after rise 48, pulse `wr_en` with the latched addr and data, pulse `frame_done`, go to IGNORE.
  - TURN: ignore rises 17..DLY_LEN+16. On the `sclk_fall` after rise 18, drive `miso`=data[31], set `miso_oe`=1, go to RDATA.
  - RDATA: on each later `sclk_fall`, shift out the next bit. The master samples on rises 19..50. On the `sclk_fall` after rise 50, drop `miso_oe`, set `miso`=0, pulse `frame_done`, go to IGNORE.
  - IGNORE: discard all edges until `cs_rise`, then go to IDLE.
- `cs_rise` in any state other than IDLE or IGNORE aborts the frame:
  - pulse `frame_err`; no `wr_en` is issued;
  - `miso_oe`=0; go to IDLE.
- `cs_rise` in IGNORE returns to IDLE without an error.
- `cs_rise` and `sclk_rise` in the same `clk`: `cs_rise` wins and the bit is discarded.
- `cs_fall` while in IGNORE (no `cs_rise` seen) cannot occur. If it does, it is treated as `cs_rise` followed by a restart into HDR.
- `wr_addr`, `wr_data` and `rd_addr` hold their last values between strobes.

## Timing
- Reset values: `miso`=0, `miso_oe`=0, `wr_en`=0, `rd_en`=0, `frame_done`=0, `frame_err`=0, `wr_addr`=0, `wr_data`=0, `rd_addr`=0; state IDLE, counter 0.
- `rst` mid-frame aborts with no strobes. The block ignores `sclk` until a new `cs_fall` is seen after `rst` deasserts.
- Pin-to-strobe latency: `SYNC_STAGES`+1 `clk` (3 at default).
- `miso` changes `SYNC_STAGES`+2 `clk` after the `sclk` falling pin edge.
- Required `sclk` high and low times: each ≥ 4 `clk` periods. Below this, behaviour is undefined.
- `cs` setup: the falling edge must come ≥ 4 `clk` before the first `sclk` rise.
- `rd_en` fires 1 `clk` after the rise-16 strobe. Read data is latched 2 `clk` after that, well inside the turnaround.
- `wr_en` fires 1 `clk` after the rise-48 strobe.
- Frame length: 48 `sclk` for a write, 50 `sclk` for a read.

## Test plan
- Write `addr`=14'h0A5C, data=32'hDEADBEEF → exactly one `wr_en` with `wr_addr`=14'h0A5C and `wr_data`=32'hDEADBEEF, then one `frame_done`; `miso_oe` stays 0 throughout.
- Read `addr`=14'h3FFF with the back-end returning 32'h12345678 → `rd_en` once with `rd_addr`=14'h3FFF. After 2 turnaround clocks the master samples 32'h12345678 on rises 19..50; `miso_oe` is high only over that window; one `frame_done`.
- Opcode 2'b11, then 32 more `sclk` → one `frame_err`; no `wr_en`, no `rd_en`; `miso_oe`=0. The next legal write completes normally.
- `cs` deasserted after 30 bits of a write → one `frame_err`, no `wr_en`, state IDLE. A back-to-back read then returns the correct data.
- `rst` pulsed at rise 40 of a read → all outputs at reset values within 1 `clk`; no `frame_done`. A subsequent write succeeds.
- Minimum `sclk` (4 `clk` high / 4 `clk` low) with random addr/data, 100 alternating write/read pairs to the same address → every read returns the word just written.

Source files
------------

// File: rtl/spi_slave.sv
// SPI mode-0 register-access slave: oversamples the SPI pins on clk, decodes a
// {opcode, addr} header and performs one 32-bit write or read per frame.
module spi_slave #(
    parameter int unsigned HDR_LEN     = 16,
    parameter int unsigned ADD_LEN     = 14,
    parameter int unsigned DLY_LEN     = 2,
    parameter int unsigned DATA_LEN    = 32,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sclk,
    input  logic                cs,
    input  logic                mosi,
    output logic                miso,
    output logic                miso_oe,
    output logic                wr_en,
    output logic [ADD_LEN-1:0]  wr_addr,
    output logic [DATA_LEN-1:0] wr_data,
    output logic                rd_en,
    output logic [ADD_LEN-1:0]  rd_addr,
    input  logic [DATA_LEN-1:0] rd_data,
    output logic                frame_done,
    output logic                frame_err
);

    localparam int unsigned CNT_W = 6;
    localparam logic [CNT_W-1:0] HDR_LAST  = CNT_W'(HDR_LEN - 1);
    localparam logic [CNT_W-1:0] WR_LAST   = CNT_W'(HDR_LEN + DATA_LEN - 1);
    localparam logic [CNT_W-1:0] TURN_LAST = CNT_W'(HDR_LEN + DLY_LEN);
    localparam logic [CNT_W-1:0] RD_LAST   = CNT_W'(HDR_LEN + DLY_LEN + DATA_LEN);

    typedef enum logic [2:0] {
        ST_IDLE, ST_HDR, ST_WDATA, ST_TURN, ST_RDATA, ST_IGNORE
    } state_t;

    // Synchronizers, edge-detect register and registered one-clk strobes
    logic [SYNC_STAGES-1:0] sclk_s, cs_s, mosi_s;
    logic sclk_d, cs_d, mosi_q;
    logic sclk_rise, sclk_fall, cs_rise, cs_fall;

    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_s    <= '0;
            cs_s      <= '0;
            mosi_s    <= '0;
            sclk_d    <= 1'b0;
            cs_d      <= 1'b0;
            mosi_q    <= 1'b0;
            sclk_rise <= 1'b0;
            sclk_fall <= 1'b0;
            cs_rise   <= 1'b0;
            cs_fall   <= 1'b0;
        end else begin
            sclk_s    <= {sclk_s[SYNC_STAGES-2:0], sclk};
            cs_s      <= {cs_s[SYNC_STAGES-2:0], cs};
            mosi_s    <= {mosi_s[SYNC_STAGES-2:0], mosi};
            sclk_d    <= sclk_s[SYNC_STAGES-1];
            cs_d      <= cs_s[SYNC_STAGES-1];
            mosi_q    <= mosi_s[SYNC_STAGES-1];
            sclk_rise <= sclk_s[SYNC_STAGES-1] & ~sclk_d;
            sclk_fall <= ~sclk_s[SYNC_STAGES-1] & sclk_d;
            cs_rise   <= cs_s[SYNC_STAGES-1] & ~cs_d;
            cs_fall   <= ~cs_s[SYNC_STAGES-1] & cs_d;
        end
    end

    state_t              state, state_n;
    logic [CNT_W-1:0]    cnt, cnt_n;
    logic [DATA_LEN-1:0] sr, sr_n;
    logic [ADD_LEN-1:0]  addr_q, addr_n;
    logic                rd_cap;
    logic                miso_n, miso_oe_n, wr_en_n, rd_en_n, done_n, err_n;
    logic [ADD_LEN-1:0]  wr_addr_n, rd_addr_n;
    logic [DATA_LEN-1:0] wr_data_n;
    logic [HDR_LEN-1:0]  hdr;

    assign hdr = {sr[HDR_LEN-2:0], mosi_q};

    // Next-state and next-output logic
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        sr_n      = sr;
        addr_n    = addr_q;
        miso_n    = miso;
        miso_oe_n = miso_oe;
        wr_en_n   = 1'b0;
        rd_en_n   = 1'b0;
        done_n    = 1'b0;
        err_n     = 1'b0;
        wr_addr_n = wr_addr;
        wr_data_n = wr_data;
        rd_addr_n = rd_addr;

        case (state)
            ST_IDLE: begin
                miso_n    = 1'b0;
                miso_oe_n = 1'b0;
                if (cs_fall) begin
                    state_n = ST_HDR;
                    cnt_n   = '0;
                    sr_n    = '0;
                end
            end
            ST_HDR, ST_WDATA: begin
                if (cs_rise) begin
                    err_n   = 1'b1;
                    state_n = ST_IDLE;
                end else if (sclk_rise) begin
                    sr_n  = {sr[DATA_LEN-2:0], mosi_q};
                    cnt_n = cnt + CNT_W'(1);
                    if (state == ST_HDR && cnt == HDR_LAST) begin
                        addr_n = hdr[ADD_LEN-1:0];
                        case (hdr[HDR_LEN-1 -: 2])
                            2'b01: state_n = ST_WDATA;
                            2'b10: begin
                                rd_en_n   = 1'b1;
                                rd_addr_n = hdr[ADD_LEN-1:0];
                                state_n   = ST_TURN;
                            end
                            default: begin
                                err_n   = 1'b1;
                                state_n = ST_IGNORE;
                            end
                        endcase
                    end else if (state == ST_WDATA && cnt == WR_LAST) begin
                        wr_en_n   = 1'b1;
                        wr_addr_n = addr_q;
                        wr_data_n = {sr[DATA_LEN-2:0], mosi_q};
                        done_n    = 1'b1;
                        state_n   = ST_IGNORE;
                    end
                end
            end
            ST_TURN: begin
                if (cs_rise) begin
                    err_n   = 1'b1;
                    state_n = ST_IDLE;
                end else begin
                    if (rd_cap)
                        sr_n = rd_data;
                    if (sclk_rise) begin
                        cnt_n = cnt + CNT_W'(1);
                    end else if (sclk_fall && cnt == TURN_LAST) begin
                        miso_n    = sr[DATA_LEN-1];
                        miso_oe_n = 1'b1;
                        sr_n      = {sr[DATA_LEN-2:0], 1'b0};
                        state_n   = ST_RDATA;
                    end
                end
            end
            ST_RDATA: begin
                if (cs_rise) begin
                    err_n     = 1'b1;
                    miso_n    = 1'b0;
                    miso_oe_n = 1'b0;
                    state_n   = ST_IDLE;
                end else if (sclk_rise) begin
                    cnt_n = cnt + CNT_W'(1);
                end else if (sclk_fall) begin
                    if (cnt == RD_LAST) begin
                        miso_n    = 1'b0;
                        miso_oe_n = 1'b0;
                        done_n    = 1'b1;
                        state_n   = ST_IGNORE;
                    end else begin
                        miso_n = sr[DATA_LEN-1];
                        sr_n   = {sr[DATA_LEN-2:0], 1'b0};
                    end
                end
            end
            ST_IGNORE: begin
                // A cs_fall here means a missed cs_rise: restart straight into a new header
                if (cs_rise) begin
                    state_n = ST_IDLE;
                end else if (cs_fall) begin
                    state_n = ST_HDR;
                    cnt_n   = '0;
                    sr_n    = '0;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            sr         <= '0;
            addr_q     <= '0;
            rd_cap     <= 1'b0;
            miso       <= 1'b0;
            miso_oe    <= 1'b0;
            wr_en      <= 1'b0;
            rd_en      <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            rd_addr    <= '0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            sr         <= sr_n;
            addr_q     <= addr_n;
            rd_cap     <= rd_en;
            miso       <= miso_n;
            miso_oe    <= miso_oe_n;
            wr_en      <= wr_en_n;
            rd_en      <= rd_en_n;
            frame_done <= done_n;
            frame_err  <= err_n;
            wr_addr    <= wr_addr_n;
            wr_data    <= wr_data_n;
            rd_addr    <= rd_addr_n;
        end
    end

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: bit-banged SPI master plus a memory back-end.
module tb_spi_slave;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sclk = 1'b0;
    logic        cs = 1'b1;
    logic        mosi = 1'b0;
    logic        miso, miso_oe, wr_en, rd_en, frame_done, frame_err;
    logic [13:0] wr_addr, rd_addr;
    logic [31:0] wr_data;
    logic [31:0] rd_data = 32'h0;

    int compared = 0;
    int mismatched = 0;

    spi_slave dut (
        .clk(clk), .rst(rst), .sclk(sclk), .cs(cs), .mosi(mosi),
        .miso(miso), .miso_oe(miso_oe),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .frame_done(frame_done), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    // Register back-end and strobe monitors
    logic [31:0] mem [0:16383];
    int          wr_cnt = 0, rd_cnt = 0, done_cnt = 0, err_cnt = 0, oe_clks = 0;
    logic [13:0] last_rd_addr = 14'h0;
    logic [13:0] last_wr_addr = 14'h0;
    logic [31:0] last_wr_data = 32'h0;

    always @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
            wr_cnt       <= wr_cnt + 1;
            last_wr_addr <= wr_addr;
            last_wr_data <= wr_data;
        end
        if (rd_en) begin
            rd_data      <= mem[rd_addr];
            rd_cnt       <= rd_cnt + 1;
            last_rd_addr <= rd_addr;
        end
        if (frame_done) done_cnt <= done_cnt + 1;
        if (frame_err)  err_cnt  <= err_cnt + 1;
        if (miso_oe)    oe_clks  <= oe_clks + 1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] mk(input logic [1:0] op, input logic [13:0] a, input logic [31:0] d);
        return {op, a, d, 16'h0};
    endfunction

    // Mode-0 master: drive on the fall, sample miso just before each rise
    task automatic spi_frame(input int nbits, input logic [63:0] tx, input int h, input bit raise_cs,
                             output logic [63:0] rx, output int oe_all, output int oe_win);
        rx = '0;
        oe_all = 0;
        oe_win = 0;
        cs = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            mosi = tx[63-i];
            repeat (h) @(negedge clk);
            rx = {rx[62:0], miso};
            if (miso_oe) begin
                oe_all++;
                if (i >= 18 && i < 50) oe_win++;
            end
            sclk = 1'b1;
            repeat (h) @(negedge clk);
            sclk = 1'b0;
        end
        repeat (h) @(negedge clk);
        if (raise_cs) begin
            cs = 1'b1;
            repeat (6) @(negedge clk);
        end
    endtask

    int          s_wr, s_rd, s_done, s_err, s_oe;
    logic [63:0] rx;
    int          oe_all, oe_win;

    task automatic snap();
        s_wr = wr_cnt;
        s_rd = rd_cnt;
        s_done = done_cnt;
        s_err = err_cnt;
        s_oe = oe_clks;
    endtask

    initial begin
        mem[14'h3FFF] = 32'h12345678;
        repeat (4) @(negedge clk);
        check("rst_miso", 64'(miso), 64'h0);
        check("rst_miso_oe", 64'(miso_oe), 64'h0);
        check("rst_wr_en", 64'(wr_en), 64'h0);
        check("rst_rd_en", 64'(rd_en), 64'h0);
        check("rst_done", 64'(frame_done), 64'h0);
        check("rst_err", 64'(frame_err), 64'h0);
        check("rst_wr_addr", 64'(wr_addr), 64'h0);
        check("rst_wr_data", 64'(wr_data), 64'h0);
        check("rst_rd_addr", 64'(rd_addr), 64'h0);
        rst = 1'b0;
        repeat (8) @(negedge clk);

        // Write 0A5C <= DEADBEEF
        snap();
        spi_frame(48, mk(2'b01, 14'h0A5C, 32'hDEADBEEF), 6, 1'b1, rx, oe_all, oe_win);
        check("w1_wr_cnt", 64'(wr_cnt - s_wr), 64'd1);
        check("w1_wr_addr", 64'(last_wr_addr), 64'h0A5C);
        check("w1_wr_data", 64'(last_wr_data), 64'hDEADBEEF);
        check("w1_hold_addr", 64'(wr_addr), 64'h0A5C);
        check("w1_done", 64'(done_cnt - s_done), 64'd1);
        check("w1_err", 64'(err_cnt - s_err), 64'd0);
        check("w1_oe_clks", 64'(oe_clks - s_oe), 64'd0);

        // Read 3FFF -> 12345678; miso_oe high for exactly 32 bit times
        snap();
        spi_frame(50, mk(2'b10, 14'h3FFF, 32'h0), 6, 1'b1, rx, oe_all, oe_win);
        check("r1_rd_cnt", 64'(rd_cnt - s_rd), 64'd1);
        check("r1_rd_addr", 64'(last_rd_addr), 64'h3FFF);
        check("r1_data", 64'(rx[31:0]), 64'h12345678);
        check("r1_oe_win", 64'(oe_win), 64'd32);
        check("r1_oe_all", 64'(oe_all), 64'd32);
        check("r1_oe_clks", 64'(oe_clks - s_oe), 64'd384);
        check("r1_done", 64'(done_cnt - s_done), 64'd1);
        check("r1_oe_after", 64'(miso_oe), 64'h0);

        // Illegal opcode 11 plus 32 more clocks
        snap();
        spi_frame(48, mk(2'b11, 14'h0A5C, 32'h0BADF00D), 6, 1'b1, rx, oe_all, oe_win);
        check("ill_err", 64'(err_cnt - s_err), 64'd1);
        check("ill_wr", 64'(wr_cnt - s_wr), 64'd0);
        check("ill_rd", 64'(rd_cnt - s_rd), 64'd0);
        check("ill_done", 64'(done_cnt - s_done), 64'd0);
        check("ill_oe_clks", 64'(oe_clks - s_oe), 64'd0);
        snap();
        spi_frame(48, mk(2'b01, 14'h0123, 32'hCAFEF00D), 6, 1'b1, rx, oe_all, oe_win);
        check("w2_wr_cnt", 64'(wr_cnt - s_wr), 64'd1);
        check("w2_wr_addr", 64'(last_wr_addr), 64'h0123);
        check("w2_wr_data", 64'(last_wr_data), 64'hCAFEF00D);
        check("w2_done", 64'(done_cnt - s_done), 64'd1);

        // Abort a write after 30 bits, then read the untouched word back
        snap();
        spi_frame(30, mk(2'b01, 14'h0A5C, 32'h11111111), 6, 1'b1, rx, oe_all, oe_win);
        check("ab_err", 64'(err_cnt - s_err), 64'd1);
        check("ab_wr", 64'(wr_cnt - s_wr), 64'd0);
        check("ab_done", 64'(done_cnt - s_done), 64'd0);
        snap();
        spi_frame(50, mk(2'b10, 14'h0A5C, 32'h0), 6, 1'b1, rx, oe_all, oe_win);
        check("ab_rd_data", 64'(rx[31:0]), 64'hDEADBEEF);
        check("ab_rd_done", 64'(done_cnt - s_done), 64'd1);
        check("ab_rd_err", 64'(err_cnt - s_err), 64'd0);

        // Reset at rise 40 of a read
        snap();
        spi_frame(40, mk(2'b10, 14'h0123, 32'h0), 6, 1'b0, rx, oe_all, oe_win);
        check("rr_oe_before", 64'(miso_oe), 64'h1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rr_miso_oe", 64'(miso_oe), 64'h0);
        check("rr_miso", 64'(miso), 64'h0);
        check("rr_wr_addr", 64'(wr_addr), 64'h0);
        check("rr_wr_data", 64'(wr_data), 64'h0);
        check("rr_rd_addr", 64'(rd_addr), 64'h0);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        cs = 1'b1;
        repeat (8) @(negedge clk);
        check("rr_done", 64'(done_cnt - s_done), 64'd0);
        check("rr_err", 64'(err_cnt - s_err), 64'd0);
        snap();
        spi_frame(48, mk(2'b01, 14'h2222, 32'h55AA33CC), 6, 1'b1, rx, oe_all, oe_win);
        check("rr_w_cnt", 64'(wr_cnt - s_wr), 64'd1);
        check("rr_w_addr", 64'(wr_addr), 64'h2222);
        check("rr_w_data", 64'(wr_data), 64'h55AA33CC);

        // Minimum sclk timing: write/read pairs to random addresses
        for (int n = 0; n < 100; n++) begin
            logic [13:0] a;
            logic [31:0] d;
            a = 14'($urandom_range(0, 16383));
            d = $urandom;
            spi_frame(48, mk(2'b01, a, d), 4, 1'b1, rx, oe_all, oe_win);
            spi_frame(50, mk(2'b10, a, 32'h0), 4, 1'b1, rx, oe_all, oe_win);
            check($sformatf("rnd%0d_a%0h", n, a), 64'(rx[31:0]), 64'(d));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
